// File: rtl/ff_pipe_pkg.sv
// Shared helpers for ff_pipe: occupancy-count width derived from the pipeline depth.
package ff_pipe_pkg;

  function automatic int cw_of(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/ff_stage.sv
// One valid-tagged WIDTH-bit register stage; loads when told, flush clears only the valid bit.
module ff_stage
  import ff_pipe_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             flush,
  input  logic             in_vld,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_vld,
  output logic [WIDTH-1:0] out_data
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_vld  <= 1'b0;
      out_data <= '0;
    end else if (flush) begin
      out_vld <= 1'b0;
    end else if (load) begin
      out_vld <= in_vld;
      // Empty slots keep their old payload to avoid needless toggling.
      if (in_vld) out_data <= in_data;
    end
  end

endmodule

// File: rtl/ff_pipe.sv
// DEPTH-stage stallable delay line, DEPTH cycles latency, valid/ready at both ends.
// Default: lockstep global stall; FF_PIPE_COLLAPSE_EN: per-stage moves that squeeze out bubbles.
module ff_pipe
  import ff_pipe_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int CW    = cw_of(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clk_en,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic [CW-1:0]    count
);

  typedef struct packed {
    logic             vld;
    logic [WIDTH-1:0] dat;
  } stage_t;

  stage_t           src [DEPTH];
  logic [DEPTH-1:0] vld;
  logic [WIDTH-1:0] dat [DEPTH];
  logic [DEPTH-1:0] load;
  logic [DEPTH-1:0] vld_nxt;
  logic [CW-1:0]    count_nxt;
  logic             en;

  assign en = clk_en & ~flush;

`ifdef FF_PIPE_COLLAPSE_EN
  // A stage may move if it or any stage downstream of it is empty, or the sink takes a word.
  always_comb begin
    logic all_vld;
    all_vld = 1'b1;
    load    = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      all_vld = all_vld & vld[i];
      load[i] = en & (out_ready | ~all_vld);
    end
  end
`else
  logic adv;
  assign adv  = en & (out_ready | ~vld[DEPTH-1]);
  assign load = {DEPTH{adv}};
`endif

  assign in_ready = load[0];

  always_comb begin
    src[0].vld = in_valid;
    src[0].dat = in_data;
    for (int i = 1; i < DEPTH; i++) begin
      src[i].vld = vld[i-1];
      src[i].dat = dat[i-1];
    end
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    ff_stage #(.WIDTH(WIDTH)) u_stage (
      .clk      (clk),
      .rst      (rst),
      .load     (load[i]),
      .flush    (flush),
      .in_vld   (src[i].vld),
      .in_data  (src[i].dat),
      .out_vld  (vld[i]),
      .out_data (dat[i])
    );
  end

  // Count tracks the valid vector the stages are about to hold.
  always_comb begin
    vld_nxt   = '0;
    count_nxt = '0;
    for (int i = 0; i < DEPTH; i++) begin
      vld_nxt[i] = flush ? 1'b0 : (load[i] ? src[i].vld : vld[i]);
      count_nxt  = count_nxt + CW'(vld_nxt[i]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) count <= '0;
    else     count <= count_nxt;
  end

  assign out_valid = vld[DEPTH-1];
  assign out_data  = dat[DEPTH-1];

endmodule

// File: tb/tb_ff_pipe.sv
// Directed stimulus on a DEPTH=4 and a DEPTH=1 pipeline, with per-instance scoreboards on data order.
module tb_ff_pipe;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       a_clk_en, a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
  logic [7:0] a_in_data, a_out_data;
  logic [2:0] a_count;

  logic       b_clk_en, b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [7:0] b_in_data, b_out_data;
  logic [0:0] b_count;

  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0] qa[$];
  logic [7:0] qb[$];

  ff_pipe #(.WIDTH(8), .DEPTH(4)) u_a (
    .clk(clk), .rst(rst), .clk_en(a_clk_en), .flush(a_flush),
    .in_valid(a_in_valid), .in_data(a_in_data), .in_ready(a_in_ready),
    .out_valid(a_out_valid), .out_data(a_out_data), .out_ready(a_out_ready),
    .count(a_count)
  );

  ff_pipe #(.WIDTH(8), .DEPTH(1)) u_b (
    .clk(clk), .rst(rst), .clk_en(b_clk_en), .flush(b_flush),
    .in_valid(b_in_valid), .in_data(b_in_data), .in_ready(b_in_ready),
    .out_valid(b_out_valid), .out_data(b_out_data), .out_ready(b_out_ready),
    .count(b_count)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (rst || a_flush) qa.delete();
    else begin
      if (a_out_valid && a_out_ready && a_clk_en) begin
        chk("a_sb_pending", 32'(qa.size() != 0), 32'd1);
        if (qa.size() != 0) chk("a_sb_data", 32'(a_out_data), 32'(qa.pop_front()));
      end
      if (a_in_valid && a_in_ready) qa.push_back(a_in_data);
    end
  end

  always @(negedge clk) begin
    if (rst || b_flush) qb.delete();
    else begin
      if (b_out_valid && b_out_ready && b_clk_en) begin
        chk("b_sb_pending", 32'(qb.size() != 0), 32'd1);
        if (qb.size() != 0) chk("b_sb_data", 32'(b_out_data), 32'(qb.pop_front()));
      end
      if (b_in_valid && b_in_ready) qb.push_back(b_in_data);
    end
  end

  initial begin
    rst = 1'b1;
    a_clk_en = 0; a_flush = 0; a_in_valid = 0; a_in_data = 0; a_out_ready = 0;
    b_clk_en = 0; b_flush = 0; b_in_valid = 0; b_in_data = 0; b_out_ready = 0;
    #1;
    chk("rst_out_valid", 32'(a_out_valid), 0);
    chk("rst_out_data",  32'(a_out_data), 0);
    chk("rst_count",     32'(a_count), 0);
    chk("rst_in_ready",  32'(a_in_ready), 0);
    chk("rst_b_valid",   32'(b_out_valid), 0);
    tick();
    rst = 1'b0;

    // Reset in the middle of a fill
    a_clk_en = 1; a_out_ready = 1;
    a_in_valid = 1; a_in_data = 8'h11; tick();
    a_in_data = 8'h22; tick();
    a_in_data = 8'h33; tick();
    a_in_valid = 0;
    chk("fill_count", 32'(a_count), 3);
    #1 rst = 1'b1;
    #1;
    chk("rst_async_count", 32'(a_count), 0);
    chk("rst_async_valid", 32'(a_out_valid), 0);
    chk("rst_async_data",  32'(a_out_data), 0);
    tick();
    rst = 1'b0;
    tick();
    chk("post_rst_count", 32'(a_count), 0);
    chk("post_rst_valid", 32'(a_out_valid), 0);

    // Full-rate streaming
    for (int c = 1; c <= 12; c++) begin
      a_in_valid = (c <= 8);
      a_in_data  = 8'(c);
      tick();
      if (c >= 4 && c <= 11) begin
        chk("stream_valid", 32'(a_out_valid), 1);
        chk("stream_data",  32'(a_out_data), 32'(c - 3));
      end
      if (c >= 4 && c <= 8) chk("stream_count", 32'(a_count), 4);
    end
    chk("stream_empty", 32'(a_count), 0);

    // Clock-enable gating
    a_in_valid = 1; a_in_data = 8'hA0; tick();
    a_in_data = 8'hA1; tick();
    a_clk_en = 0; a_in_data = 8'hEE;
    #1 chk("gate_ready", 32'(a_in_ready), 0);
    repeat (3) begin
      tick();
      chk("gate_count", 32'(a_count), 2);
      chk("gate_valid", 32'(a_out_valid), 0);
      chk("gate_ready_hold", 32'(a_in_ready), 0);
    end
    a_clk_en = 1; a_in_valid = 0;
    tick();
    chk("gate_not_yet", 32'(a_out_valid), 0);
    tick();
    chk("gate_first_vld", 32'(a_out_valid), 1);
    chk("gate_first",     32'(a_out_data), 32'h A0);
    tick();
    chk("gate_second", 32'(a_out_data), 32'hA1);
    tick();
    chk("gate_empty", 32'(a_count), 0);

    // Back-pressure with a bubble between two words
    a_in_valid = 1; a_in_data = 8'h55; tick();
    a_in_valid = 0; tick();
    a_in_valid = 1; a_in_data = 8'h66; tick();
    a_in_valid = 0; tick();
    chk("bp_head", 32'(a_out_data), 32'h55);
    a_out_ready = 0;
    #1;
`ifdef FF_PIPE_COLLAPSE_EN
    chk("bp_ready", 32'(a_in_ready), 1);
`else
    chk("bp_ready", 32'(a_in_ready), 0);
`endif
    repeat (3) begin
      tick();
      chk("bp_count", 32'(a_count), 2);
`ifdef FF_PIPE_COLLAPSE_EN
      chk("bp_ready_hold", 32'(a_in_ready), 1);
`else
      chk("bp_ready_hold", 32'(a_in_ready), 0);
`endif
    end
    a_out_ready = 1;
    #1;
    chk("bp_out0_valid", 32'(a_out_valid), 1);
    chk("bp_out0_data",  32'(a_out_data), 32'h55);
    tick();
`ifdef FF_PIPE_COLLAPSE_EN
    chk("bp_next_valid", 32'(a_out_valid), 1);
    chk("bp_next_data",  32'(a_out_data), 32'h66);
`else
    chk("bp_bubble", 32'(a_out_valid), 0);
    tick();
    chk("bp_next_valid", 32'(a_out_valid), 1);
    chk("bp_next_data",  32'(a_out_data), 32'h66);
`endif
    repeat (2) tick();
    chk("bp_empty", 32'(a_count), 0);

    // Flush colliding with input and output transfers while gated
    a_in_valid = 1; a_in_data = 8'h31; tick();
    a_in_data = 8'h32; tick();
    a_in_data = 8'h33; tick();
    a_in_valid = 0; tick();
    chk("pre_flush_count", 32'(a_count), 3);
    chk("pre_flush_data",  32'(a_out_data), 32'h31);
    a_flush = 1; a_clk_en = 0; a_in_valid = 1; a_in_data = 8'h99; a_out_ready = 1;
    #1 chk("flush_ready", 32'(a_in_ready), 0);
    tick();
    chk("flush_count", 32'(a_count), 0);
    chk("flush_valid", 32'(a_out_valid), 0);
    chk("flush_data_kept", 32'(a_out_data), 32'h31);
    a_flush = 0; a_clk_en = 1; a_in_valid = 0;
    repeat (4) tick();
    chk("post_flush_count", 32'(a_count), 0);
    chk("post_flush_valid", 32'(a_out_valid), 0);

    // Single-stage pass-through
    b_clk_en = 1; b_out_ready = 1; b_in_valid = 1; b_in_data = 8'h7E;
    #1 chk("d1_ready0", 32'(b_in_ready), 1);
    tick();
    chk("d1_valid0", 32'(b_out_valid), 1);
    chk("d1_data0",  32'(b_out_data), 32'h7E);
    b_in_data = 8'h7F;
    #1 chk("d1_ready1", 32'(b_in_ready), 1);
    tick();
    chk("d1_data1",  32'(b_out_data), 32'h7F);
    chk("d1_count1", 32'(b_count), 1);
    b_in_valid = 0;
    tick();
    chk("d1_valid_end", 32'(b_out_valid), 0);
    chk("d1_count_end", 32'(b_count), 0);

    tick();
    chk("a_drain", 32'(qa.size()), 0);
    chk("b_drain", 32'(qb.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ff_pipe.md
# ff_pipe

Parametrised, clock-enabled register pipeline: DEPTH stages of WIDTH-bit data, each stage tagged with a valid bit, with a valid/ready handshake at both ends, synchronous flush and an occupancy count. It generalises the single clock-enabled D flip-flop into a multi-bit, multi-stage delay line with back-pressure. It sits between datapath blocks that need a fixed-latency, stallable delay.

## Interface
- WIDTH, 8, data width in bits (≥1)
- DEPTH, 4, number of register stages (≥1)
- CW, $clog2(DEPTH+1), width of the occupancy count (derived; do not override)

- clk  input  1  clock; all state updates on the rising edge
- rst  input  1  reset; asynchronous, active-high
- clk_en  input  1  global enable; when low, no stage moves
- flush  input  1  synchronous clear of all valid bits
- in_valid  input  1  in_data is valid
- in_data  input  WIDTH  input word
- in_ready  output  1  pipeline accepts in_data this cycle (combinational)
- out_valid  output  1  out_data is valid (registered, = vld[DEPTH-1])
- out_data  output  WIDTH  output word (registered, = data[DEPTH-1])
- out_ready  input  1  downstream accepts out_data
- count  output  CW  number of valid stages (registered)

## Operation
- State: data[i], vld[i], i = 0..DEPTH-1; stage 0 is the input end, stage DEPTH-1 drives the outputs.
- Reset (rst high, asynchronous): all vld = 0, all data = 0, count = 0. Outputs: out_valid = 0, out_data = 0, count = 0. in_ready follows its equation (0 when clk_en low).
- Lockstep mode (default): advance = clk_en & ~flush & (out_ready | ~vld[DEPTH-1]); in_ready = advance. On advance: vld[0] <= in_valid; data[0] <= in_data only if in_valid, otherwise held; stage i <= stage i-1 for i ≥ 1. Without advance, everything holds.
- Input transfer: in_valid & in_ready. Output transfer: out_valid & out_ready & clk_en & ~flush.
- flush: acts regardless of clk_en. On the edge it clears all vld bits and sets count = 0, leaving data unchanged. It takes priority over simultaneous input and output transfers; neither occurs.
- count: next value = popcount of next vld vector; always equals the number of set vld bits.
- clk_en low: no transfers, in_ready = 0, out_ready ignored, and all state holds (except flush).
- DEPTH = 1: the single stage is both input and output; simultaneous input and output transfers in one cycle are allowed (pass-through at full rate).

## Timing
- Latency: a word accepted at edge N appears on out_data/out_valid after edge N+DEPTH-1, i.e. DEPTH cycles, given no stalls.
- Throughput: one word per cycle while clk_en = 1 and out_ready = 1.
- in_ready depends combinationally on clk_en, flush, out_ready and vld[DEPTH-1]. There is no combinational path from in_valid or in_data to any output.
- Full pipeline with out_ready = 0: in_ready = 0, and state holds.

## Configuration
- FF_PIPE_COLLAPSE_EN defined: bubble-collapsing mode. Each stage moves independently.
  - go[DEPTH-1] = ~vld[DEPTH-1] | out_ready
  - go[i] = ~vld[i] | go[i+1]
  - All terms are gated by clk_en & ~flush.
  - Stage i loads from stage i-1 when go[i]. A stage that receives an empty upstream value becomes invalid.
  - in_ready = go[0].
  - Stalled valid words stay put while empty slots behind them fill, so up to DEPTH words queue under back-pressure.
- Not defined: lockstep mode as above. Bubbles are preserved and the stall is global.

## Structure
- Package ff_pipe_pkg holds the stage record typedef (valid + data, parametrised through a WIDTH-generic function or a localparam-sized struct in the user) and the function computing CW from DEPTH.
- Sub-module ff_stage: one WIDTH-bit valid-tagged register. Ports: clk, rst, load, flush, in_vld, in_data, out_vld, out_data. The top instantiates DEPTH copies in a generate loop and computes the load/go chain.

## Test plan
(WIDTH = 8, DEPTH = 4 unless stated.)
- Reset mid-stream: fill with 0x11, 0x22, 0x33, assert rst between edges → out_valid, out_data and count go to 0 immediately, without waiting for an edge; after release, pipeline empty.
- Streaming: out_ready = 1, clk_en = 1, inject 0x01..0x08 on consecutive cycles → 0x01 is on the outputs after the 4th edge, then one word per cycle in order; count stays 4 during the steady state.
- clk_en gating: stream 0xA0, 0xA1, drop clk_en for 3 cycles → no state change, in_ready = 0; resume → words emerge in order with latency extended by exactly 3 cycles.
- Back-pressure:
  - Lockstep: inject 0x55 with a one-cycle gap, then 0x66; out_ready = 0 once 0x55 reaches the output → count = 2 and in_ready = 0; raise out_ready → 0x55, then one bubble, then 0x66.
  - With FF_PIPE_COLLAPSE_EN: the same stimulus → in_ready stays 1 until count = 4; the bubble disappears.
- Flush collision: pipeline holding 3 words, flush = 1 together with in_valid = 1, out_ready = 1, clk_en = 0 → after the edge, count = 0 and out_valid = 0; no word is accepted or delivered.
- DEPTH = 1: out_ready = 1, inject 0x7E, 0x7F back-to-back → each appears one cycle after acceptance; in_ready stays 1 throughout.
